jk_cmd_sequencer: RTL

Upstream command stage for the JK flip-flop. It accepts hold/reset/set/toggle commands over a valid/ready handshake and buffers them in a small FIFO. Each command drives registered `j`/`k` for a programmable number of clock cycles. It also keeps a cycle-accurate reference model of the downstream flip-flop's `q`, so the flip-flop can be exercised and checked without a hand-timed testbench.

---
 rtl/jk_cmd_sequencer.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/jk_cmd_sequencer.sv
// Command FIFO + two-state driver producing registered j/k for a downstream JK flip-flop,
// with a cycle-accurate model of its q. Define JK_SEQ_CHECK_EN to add the q_dut/mismatch checker.
module jk_cmd_sequencer #(
    parameter int DEPTH = 4,
    parameter int REP_W = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [1:0]               cmd_op,
    input  logic [REP_W-1:0]         cmd_rep,
    output logic                     j,
    output logic                     k,
    output logic                     busy,
    output logic                     q_model,
    output logic [$clog2(DEPTH):0]   fifo_count
`ifdef JK_SEQ_CHECK_EN
    ,
    input  logic                     q_dut,
    output logic                     mismatch
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = 2 + REP_W;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    typedef enum logic {IDLE, DRIVE} state_t;

    state_t             state_q, state_d;
    logic [ENT_W-1:0]   mem_q [DEPTH];
    logic [ENT_W-1:0]   mem_d [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [REP_W-1:0]   rep_q, rep_d;
    logic               j_q, j_d;
    logic               k_q, k_d;
    logic               busy_q, busy_d;
    logic               qm_q, qm_d;
    logic               push, pop;
    logic [ENT_W-1:0]   head;

    assign cmd_ready = (count_q != FULL);
    assign head      = mem_q[rd_ptr_q];

    always_comb begin
        state_d  = state_q;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        rep_d    = rep_q;
        j_d      = j_q;
        k_d      = k_q;
        busy_d   = busy_q;
        pop      = 1'b0;
        push     = cmd_valid && cmd_ready;

        // A pop happens from IDLE, or on the last DRIVE cycle, whenever the queue holds an entry.
        unique case (state_q)
            IDLE: begin
                j_d    = 1'b0;
                k_d    = 1'b0;
                busy_d = 1'b0;
                if (count_q != '0) begin
                    pop = 1'b1;
                end
            end
            DRIVE: begin
                if (rep_q != '0) begin
                    rep_d = rep_q - REP_W'(1);
                end else if (count_q != '0) begin
                    pop = 1'b1;
                end else begin
                    state_d = IDLE;
                    j_d     = 1'b0;
                    k_d     = 1'b0;
                    busy_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        if (pop) begin
            state_d  = DRIVE;
            j_d      = head[ENT_W-1];
            k_d      = head[ENT_W-2];
            rep_d    = head[REP_W-1:0];
            busy_d   = 1'b1;
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        if (push) begin
            mem_d[wr_ptr_q] = {cmd_op, cmd_rep};
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end

        count_d = count_q + CNT_W'(push) - CNT_W'(pop);

        unique case ({j_q, k_q})
            2'b01:   qm_d = 1'b0;
            2'b10:   qm_d = 1'b1;
            2'b11:   qm_d = ~qm_q;
            default: qm_d = qm_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            rep_q    <= '0;
            j_q      <= 1'b0;
            k_q      <= 1'b0;
            busy_q   <= 1'b0;
            qm_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            rep_q    <= rep_d;
            j_q      <= j_d;
            k_q      <= k_d;
            busy_q   <= busy_d;
            qm_q     <= qm_d;
        end
    end

    assign j          = j_q;
    assign k          = k_q;
    assign busy       = busy_q;
    assign q_model    = qm_q;
    assign fifo_count = count_q;

`ifdef JK_SEQ_CHECK_EN
    // armed_q masks the compare during the first cycle after reset release.
    logic armed_q, armed_d;
    logic mismatch_q, mismatch_d;

    always_comb begin
        armed_d    = 1'b1;
        mismatch_d = mismatch_q | (armed_q & (q_dut != qm_q));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            armed_q    <= 1'b0;
            mismatch_q <= 1'b0;
        end else begin
            armed_q    <= armed_d;
            mismatch_q <= mismatch_d;
        end
    end

    assign mismatch = mismatch_q;
`endif

endmodule
